// File: rtl/uc_queue_mp_pkg.sv
// Shared types and sizing helpers for the unit-clause queue and the unit clause arbiter.
// Literal width carries a sign bit on top of the variable index.
package uc_pkg;

    function automatic int lit_w(input int var_num);
        return $clog2(var_num) + 1;
    endfunction

    localparam int UCQ_DEPTH_DEFAULT   = 8;
    localparam int UCQ_VAR_NUM_DEFAULT = 512;
    localparam int LIT_W_DEFAULT       = lit_w(UCQ_VAR_NUM_DEFAULT);

    typedef logic signed [LIT_W_DEFAULT-1:0] lit_t;

endpackage

// File: rtl/uc_queue_mp_if.sv
// Producer push ports plus consumer head/status bundle of the unit-clause queue.
// master = engines/consumer side, slave = queue side.
interface uc_queue_mp_if #(
    parameter int NUM_PORTS = 4,
    parameter int LIT_W     = 10,
    parameter int CNT_W     = 4
);
    logic [NUM_PORTS-1:0]            push_valid;
    logic [NUM_PORTS-1:0][LIT_W-1:0] push_lit;
    logic [NUM_PORTS-1:0]            push_ready;
    logic                            pop;
    logic                            head_valid;
    logic [LIT_W-1:0]                head_lit;
    logic [CNT_W-1:0]                count;
    logic                            full;
    logic                            conflict;
    logic [LIT_W-1:0]                conflict_lit;

    modport master (
        output push_valid, push_lit, pop,
        input  push_ready, head_valid, head_lit, count, full, conflict, conflict_lit
    );

    modport slave (
        input  push_valid, push_lit, pop,
        output push_ready, head_valid, head_lit, count, full, conflict, conflict_lit
    );
endinterface

// File: rtl/uc_queue_mp_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from r_ptr, pointer moves past the winner on advance.
// Grant is combinational from i_req; no backpressure of its own, the caller gates advance.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic [N-1:0]  i_req,
    input  logic          i_advance,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_gnt_idx
);
    logic [IW-1:0] r_ptr;

    always_comb begin
        int  j;
        logic found;
        o_gnt     = '0;
        o_gnt_idx = '0;
        found     = 1'b0;
        j         = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(r_ptr) + k) % N;
            if (!found && i_req[j]) begin
                found     = 1'b1;
                o_gnt[j]  = 1'b1;
                o_gnt_idx = IW'(j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            r_ptr <= (o_gnt_idx == IW'(N - 1)) ? '0 : o_gnt_idx + IW'(1);
        end
    end

endmodule

// File: rtl/uc_queue_mp.sv
// Multi-producer unit-clause queue: RR admits one literal/cycle, drops duplicates, flags complements; FWFT head.
// Accepted literal reaches head_lit 1 cycle later when empty; ready only when not full or a pop frees a slot.
module uc_queue_mp
    import uc_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int DEPTH     = UCQ_DEPTH_DEFAULT,
    parameter int VAR_NUM   = UCQ_VAR_NUM_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    uc_queue_mp_if.slave bus
);
    localparam int LIT_W = lit_w(VAR_NUM);
    localparam int AW    = $clog2(DEPTH);
    localparam int PW    = AW + 1;
    localparam int IW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic signed [LIT_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]           r_head;
    logic [PW-1:0]           r_tail;
    logic                    r_conflict;
    logic signed [LIT_W-1:0] r_conflict_lit;

    logic [PW-1:0]           w_count;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_pop_eff;
    logic                    w_flush;
    logic                    w_space;
    logic                    w_xfer;
    logic                    w_nonzero;
    logic                    w_dup;
    logic                    w_cpl;
    logic                    w_store;
    logic [NUM_PORTS-1:0]    w_gnt;
    logic [IW-1:0]           w_gnt_idx;
    logic signed [LIT_W-1:0] w_lit;
    logic signed [LIT_W-1:0] w_neg;
    logic [DEPTH-1:0]        w_occ;
    logic [DEPTH-1:0]        w_eq;
    logic [DEPTH-1:0]        w_ceq;

    assign w_count   = r_tail - r_head;
    assign w_full    = (w_count == PW'(DEPTH));
    assign w_empty   = (w_count == '0);
    assign w_pop_eff = bus.pop && !w_empty;
    assign w_flush   = rst || clear;
    assign w_space   = !w_full || w_pop_eff;

    rr_arbiter #(.N(NUM_PORTS)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (clear),
        .i_req     (bus.push_valid),
        .i_advance (w_xfer),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx)
    );

    assign bus.push_ready = (w_flush || !w_space) ? '0 : w_gnt;
    assign w_xfer         = |(bus.push_valid & bus.push_ready);
    assign w_lit          = bus.push_lit[w_gnt_idx];
    assign w_neg          = -w_lit;
    assign w_nonzero      = (w_lit != '0);

    // Compare against every live slot, including a head leaving this same cycle.
    always_comb begin
        logic [AW-1:0] off;
        off   = '0;
        w_occ = '0;
        w_eq  = '0;
        w_ceq = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off      = AW'(i) - r_head[AW-1:0];
            w_occ[i] = ({1'b0, off} < w_count);
            w_eq[i]  = w_occ[i] && (r_mem[i] == w_lit);
            w_ceq[i] = w_occ[i] && (r_mem[i] == w_neg);
        end
    end

    assign w_dup   = |w_eq;
    assign w_cpl   = |w_ceq;
    assign w_store = w_xfer && w_nonzero && !w_dup && !w_cpl;

    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_head         <= '0;
            r_tail         <= '0;
            r_conflict     <= 1'b0;
            r_conflict_lit <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_pop_eff) begin
                r_head <= r_head + PW'(1);
            end
            if (w_store) begin
                r_mem[r_tail[AW-1:0]] <= w_lit;
                r_tail                <= r_tail + PW'(1);
            end
            if (w_xfer && w_nonzero && !w_dup && w_cpl) begin
                r_conflict <= 1'b1;
                if (!r_conflict) begin
                    r_conflict_lit <= w_lit;
                end
            end
        end
    end

    assign bus.head_valid   = !w_empty;
    assign bus.head_lit     = r_mem[r_head[AW-1:0]];
    assign bus.count        = w_count;
    assign bus.full         = w_full;
    assign bus.conflict     = r_conflict;
    assign bus.conflict_lit = r_conflict_lit;

endmodule
